vreg_file_sb: RTL and testbench

Parametrised vector register file with per-lane write masking and two write ports: the issue/writeback port and the convolution-unit result port. A per-register scoreboard lets the convolution unit reserve a destination register at launch. The reservation is released when the result is written back. The issue stage uses the busy flags to stall dependent vector instructions. It sits between vector decode/issue and the conv datapath.

---
 rtl/vreg_file_sb.sv | 112 +++++++++++
 tb/tb_vreg_file_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_file_sb.sv
// Vector register file with a masked issue write port, a full-width conv result port and a
// per-register reservation scoreboard. Define VREG_BYPASS_EN for write-through read forwarding.
module vreg_file_sb #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 8,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         rA_addr,
    input  logic [ADDR_W-1:0]         rB_addr,
    output logic [LANES*ELEM_W-1:0]   rA_data,
    output logic [LANES*ELEM_W-1:0]   rB_data,
    output logic                      rA_busy,
    output logic                      rB_busy,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [LANES-1:0]          wr_mask,
    input  logic [LANES*ELEM_W-1:0]   wr_data,
    input  logic                      rsv_req,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      rsv_ok,
    input  logic                      conv_write,
    input  logic [ADDR_W-1:0]         conv_addr,
    input  logic [LANES*ELEM_W-1:0]   conv_result,
    output logic                      conv_drop,
    output logic                      waw_err,
    output logic [ADDR_W:0]           busy_cnt
);

    localparam int VW = LANES * ELEM_W;

    logic [VW-1:0]     regs_q [NREGS];
    logic [VW-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              conv_drop_q, conv_drop_d;
    logic              waw_err_q, waw_err_d;
    logic              collision;

    assign collision = wr_en && conv_write && (wr_addr == conv_addr);

    // A reservation may take over a register that the conv unit is releasing this same cycle.
    assign rsv_ok = rsv_req && (!busy_q[rsv_addr] || (conv_write && (conv_addr == rsv_addr)));

    always_comb begin
        regs_d = regs_q;
        if (conv_write && !collision) begin
            regs_d[conv_addr] = conv_result;
        end
        if (wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    regs_d[wr_addr][i*ELEM_W +: ELEM_W] = wr_data[i*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (conv_write) begin
            busy_d[conv_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        // Recounting the next busy vector keeps busy_cnt exact under simultaneous set/clear.
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
        conv_drop_d = collision;
        waw_err_d   = waw_err_q | (wr_en && (|wr_mask) && busy_q[wr_addr]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            busy_cnt_q  <= '0;
            conv_drop_q <= 1'b0;
            waw_err_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            busy_cnt_q  <= busy_cnt_d;
            conv_drop_q <= conv_drop_d;
            waw_err_q   <= waw_err_d;
        end
    end

`ifdef VREG_BYPASS_EN
    assign rA_data = regs_d[rA_addr];
    assign rB_data = regs_d[rB_addr];
    assign rA_busy = busy_d[rA_addr];
    assign rB_busy = busy_d[rB_addr];
`else
    assign rA_data = regs_q[rA_addr];
    assign rB_data = regs_q[rB_addr];
    assign rA_busy = busy_q[rA_addr];
    assign rB_busy = busy_q[rB_addr];
`endif

    assign busy_cnt  = busy_cnt_q;
    assign conv_drop = conv_drop_q;
    assign waw_err   = waw_err_q;

endmodule

// File: tb/tb_vreg_file_sb.sv
// Scoreboard bench for vreg_file_sb: directed test-plan sequence then randomized traffic,
// checked against an array-based reference model.
module tb_vreg_file_sb;

    localparam int LANES  = 16;
    localparam int ELEM_W = 8;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int VW     = LANES * ELEM_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] rA_addr, rB_addr, wr_addr, rsv_addr, conv_addr;
    logic [VW-1:0]     rA_data, rB_data, wr_data, conv_result;
    logic              rA_busy, rB_busy, wr_en, rsv_req, rsv_ok, conv_write, conv_drop, waw_err;
    logic [LANES-1:0]  wr_mask;
    logic [ADDR_W:0]   busy_cnt;

    vreg_file_sb #(.LANES(LANES), .ELEM_W(ELEM_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .rA_addr(rA_addr), .rB_addr(rB_addr), .rA_data(rA_data), .rB_data(rB_data),
        .rA_busy(rA_busy), .rB_busy(rB_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rsv_req(rsv_req), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .conv_write(conv_write), .conv_addr(conv_addr), .conv_result(conv_result),
        .conv_drop(conv_drop), .waw_err(waw_err), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rst;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [LANES-1:0]  wm;
        logic [VW-1:0]     wd;
        logic              cw;
        logic [ADDR_W-1:0] ca;
        logic [VW-1:0]     cd;
        logic              rq;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rda;
        logic [ADDR_W-1:0] rdb;
    } stim_t;

    typedef struct packed {
        logic [VW-1:0]   a;
        logic [VW-1:0]   b;
        logic            abusy;
        logic            bbusy;
        logic            ok;
        logic            drop;
        logic            waw;
        logic [ADDR_W:0] cnt;
    } exp_t;

    exp_t expq[$];
    exp_t me;

    // Reference model state: current contents and the state after the pending edge.
    logic [VW-1:0]    mem_m [NREGS];
    logic [VW-1:0]    nmem  [NREGS];
    logic [NREGS-1:0] busy_m, nbusy;
    logic             drop_m, waw_m, ndrop, nwaw, ok_m;
    stim_t            prev;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    endtask

    function automatic logic [VW-1:0] fill(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    function automatic stim_t idle(input int ra, input int rb);
        stim_t s;
        s     = '0;
        s.rda = ADDR_W'(ra);
        s.rdb = ADDR_W'(rb);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mem_m[i] = '0;
        busy_m = '0;
        drop_m = 1'b0;
        waw_m  = 1'b0;
    endtask

    task automatic predict(input stim_t s);
        logic coll;
        coll = s.we && s.cw && (s.wa == s.ca);
        ok_m = s.rq && (!busy_m[s.ra] || (s.cw && s.ca == s.ra));
        nbusy = busy_m;
        if (s.cw) nbusy[s.ca] = 1'b0;
        if (ok_m) nbusy[s.ra] = 1'b1;
        nmem = mem_m;
        if (s.cw && !coll) nmem[s.ca] = s.cd;
        if (s.we)
            for (int l = 0; l < LANES; l++)
                if (s.wm[l]) nmem[s.wa][l*ELEM_W +: ELEM_W] = s.wd[l*ELEM_W +: ELEM_W];
        ndrop = coll;
        nwaw  = waw_m || (s.we && (s.wm != '0) && busy_m[s.wa]);
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        if (!prev.rst) begin
            mem_m  = nmem;
            busy_m = nbusy;
            drop_m = ndrop;
            waw_m  = nwaw;
        end
        reset = s.rst;
        if (s.rst) model_reset();
        wr_en = s.we; wr_addr = s.wa; wr_mask = s.wm; wr_data = s.wd;
        conv_write = s.cw; conv_addr = s.ca; conv_result = s.cd;
        rsv_req = s.rq; rsv_addr = s.ra; rA_addr = s.rda; rB_addr = s.rdb;
        predict(s);
`ifdef VREG_BYPASS_EN
        e.a = nmem[s.rda]; e.b = nmem[s.rdb];
        e.abusy = nbusy[s.rda]; e.bbusy = nbusy[s.rdb];
`else
        e.a = mem_m[s.rda]; e.b = mem_m[s.rdb];
        e.abusy = busy_m[s.rda]; e.bbusy = busy_m[s.rdb];
`endif
        e.ok   = ok_m;
        e.drop = drop_m;
        e.waw  = waw_m;
        e.cnt  = (ADDR_W+1)'($countones(busy_m));
        expq.push_back(e);
        prev = s;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                me = expq.pop_front();
                chk("rA_data",  rA_data,   me.a);
                chk("rB_data",  rB_data,   me.b);
                chk("rA_busy",  VW'(rA_busy),  VW'(me.abusy));
                chk("rB_busy",  VW'(rB_busy),  VW'(me.bbusy));
                chk("rsv_ok",   VW'(rsv_ok),   VW'(me.ok));
                chk("conv_drop",VW'(conv_drop),VW'(me.drop));
                chk("waw_err",  VW'(waw_err),  VW'(me.waw));
                chk("busy_cnt", VW'(busy_cnt), VW'(me.cnt));
            end
        end
    end

    initial begin
        stim_t s;
        prev = '0;
        prev.rst = 1'b1;
        model_reset();
        predict(idle(0, 0));
        {wr_en, wr_addr, wr_mask, wr_data, conv_write, conv_addr, conv_result} = '0;
        {rsv_req, rsv_addr, rA_addr, rB_addr} = '0;

        s = idle(0, 0); s.rst = 1'b1;
        step(s); step(s);
        for (int i = 0; i < 16; i++) step(idle(i, i + 16));

        s = idle(3, 3); s.we = 1'b1; s.wa = 3; s.wm = '1; s.wd = fill(8'h55);
        step(s);
        s.wm = 16'h00FF; s.wd = fill(8'hAA);
        step(s);
        step(idle(3, 3));

        s = idle(7, 7); s.rq = 1'b1; s.ra = 7;
        step(s); step(s);
        s = idle(7, 7); s.cw = 1'b1; s.ca = 7; s.cd = fill(8'h11);
        step(s);
        step(idle(7, 7));

        s = idle(5, 5); s.we = 1'b1; s.wa = 5; s.wm = '1; s.wd = fill(8'h22);
        s.cw = 1'b1; s.ca = 5; s.cd = fill(8'h33);
        step(s);
        step(idle(5, 5)); step(idle(5, 5));

        s = idle(9, 9); s.rq = 1'b1; s.ra = 9;
        step(s);
        s = idle(9, 9); s.we = 1'b1; s.wa = 9; s.wm = 16'h0F0F; s.wd = fill(8'h5A);
        step(s);
        step(idle(9, 0));
        s = idle(10, 9); s.rq = 1'b1; s.ra = 10;
        step(s);
        s = idle(10, 9); s.rst = 1'b1;
        step(s);
        step(idle(10, 9));
        s = idle(10, 9); s.cw = 1'b1; s.ca = 10; s.cd = fill(8'h66);
        step(s);
        step(idle(10, 9));

        s = idle(4, 4); s.we = 1'b1; s.wa = 4; s.wm = '1; s.wd = fill(8'h77);
        step(s);
        step(idle(4, 4));

        for (int n = 0; n < 3000; n++) begin
            s.rst = ($urandom_range(0, 399) == 0);
            s.we  = ($urandom_range(0, 2) == 0);
            s.wa  = ADDR_W'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       s.wm = '0;
                1:       s.wm = '1;
                default: s.wm = LANES'($urandom);
            endcase
            s.wd  = {$urandom, $urandom, $urandom, $urandom};
            s.cw  = ($urandom_range(0, 2) == 0);
            s.ca  = ADDR_W'($urandom_range(0, 15));
            s.cd  = {$urandom, $urandom, $urandom, $urandom};
            s.rq  = ($urandom_range(0, 1) == 0);
            s.ra  = ADDR_W'($urandom_range(0, 15));
            s.rda = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            s.rdb = ADDR_W'($urandom_range(0, 15));
            step(s);
        end

        step(idle(0, 1));
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
